// File: rtl/superalu_rr_sched.sv
// Round-robin front end that time-shares one combinational SuperALU among NREQ lanes.
// One operation in flight; the tagged result is held until the consumer takes it.
module superalu_rr_sched #(
  parameter int NREQ      = 4,
  parameter int W         = 32,
  parameter int MULT_WAIT = 1,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_op_a,
  input  logic [NREQ*W-1:0] req_op_b,
  input  logic [NREQ*3-1:0] req_ctrl,
  output logic [W-1:0]      alu_op_a,
  output logic [W-1:0]      alu_op_b,
  output logic [2:0]        alu_control,
  input  logic [W-1:0]      alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic [3:0]        rsp_flags,
  output logic              busy
);

  localparam int CW = (MULT_WAIT > 1) ? $clog2(MULT_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((MULT_WAIT > 0) ? MULT_WAIT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [3:0]      flg_q, flg_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [W-1:0]    op_a_arr [NREQ];
  logic [W-1:0]    op_b_arr [NREQ];
  logic [2:0]      ctrl_arr [NREQ];
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  sidx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a_arr[gi] = req_op_a[gi*W +: W];
    assign op_b_arr[gi] = req_op_b[gi*W +: W];
    assign ctrl_arr[gi] = req_ctrl[gi*3 +: 3];
  end

  // Scan upward from the pointer with wrap; the first pending lane wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sidx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sidx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_found && req_valid[sidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = sidx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    flg_d     = flg_q;
    req_ready = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          id_d    = gnt_idx;
          a_d     = op_a_arr[gnt_idx];
          b_d     = op_b_arr[gnt_idx];
          ctrl_d  = ctrl_arr[gnt_idx];
          ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ctrl_q == 3'b100 && MULT_WAIT > 0) begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end else begin
          res_d   = alu_result;
          flg_d   = alu_flags;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          res_d   = alu_result;
          flg_d   = alu_flags;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  assign alu_op_a    = a_q;
  assign alu_op_b    = b_q;
  assign alu_control = ctrl_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flg_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_superalu_rr_sched.sv
// Bench for superalu_rr_sched: an ALU stand-in whose multiply output is only valid after settling,
// a transaction-level scheduler model checked every cycle, and directed plus random stimulus.
module tb_superalu_rr_sched;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int MW   = 1;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_op_a;
  logic [NREQ*W-1:0] req_op_b;
  logic [NREQ*3-1:0] req_ctrl;
  logic [W-1:0]      alu_op_a, alu_op_b, alu_result;
  logic [2:0]        alu_control;
  logic [3:0]        alu_flags;
  logic              rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic [3:0]        rsp_flags;

  logic [W-1:0] ra [NREQ];
  logic [W-1:0] rb [NREQ];
  logic [2:0]   rc [NREQ];

  int checks   = 0;
  int failures = 0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_op_a[gi*W +: W] = ra[gi];
    assign req_op_b[gi*W +: W] = rb[gi];
    assign req_ctrl[gi*3 +: 3] = rc[gi];
  end

  superalu_rr_sched #(.NREQ(NREQ), .W(W), .MULT_WAIT(MW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_ctrl(req_ctrl),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference SuperALU behaviour: {flags[3:0], result[31:0]}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy, ov;
    logic [3:0]  f;
    cy = 1'b0; ov = 1'b0; s = '0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                  ov = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = a - b; cy = (a < b); ov = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a * b;
      3'd5: r = a ^ b;
      3'd6: r = a >> b[4:0];
      default: r = a << b[4:0];
    endcase
    f = c[2] ? 4'b0000 : {r[31], (r == 32'd0), cy, ov};
    return {f, r};
  endfunction

  // ALU stand-in: the multiplier output is garbage until it has settled MW cycles after a grant.
  logic [3:0] settle;
  always_ff @(posedge clk) begin
    if (|req_ready) settle <= 4'd0;
    else if (settle < 4'd15) settle <= settle + 4'd1;
  end
  always_comb begin
    {alu_flags, alu_result} = alu_fn(alu_op_a, alu_op_b, alu_control);
    if (alu_control == 3'b100 && settle < 4'(MW)) begin
      alu_result = 32'hDEAD_BEEF;
      alu_flags  = 4'hF;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx[IDW-1:0]]) return idx;
    end
    return -1;
  endfunction

  // Model: phase 0 idle, 1 working (m_rem cycles left), 2 holding a response.
  int           m_phase, m_rem, m_ptr, m_id;
  logic [W-1:0] m_a, m_b, m_r;
  logic [2:0]   m_c;
  logic [3:0]   m_f;

  task automatic model_reset();
    m_phase = 0; m_rem = 0; m_ptr = 0; m_id = 0;
    m_a = '0; m_b = '0; m_c = '0; m_r = '0; m_f = '0;
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("reset_alu_op_a", 64'(alu_op_a), 64'(0));
        chk("reset_alu_control", 64'(alu_control), 64'(0));
        chk("reset_rsp_result", 64'(rsp_result), 64'(0));
        chk("reset_rsp_id", 64'(rsp_id), 64'(0));
        chk("reset_rsp_flags", 64'(rsp_flags), 64'(0));
      end
      exp_rdy = '0;
      g = (m_phase == 0) ? pick(req_valid, m_ptr) : -1;
      if (g >= 0) exp_rdy[g[IDW-1:0]] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy", 64'(busy), 64'(m_phase != 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
      if (m_phase != 0) begin
        chk("alu_op_a", 64'(alu_op_a), 64'(m_a));
        chk("alu_op_b", 64'(alu_op_b), 64'(m_b));
        chk("alu_control", 64'(alu_control), 64'(m_c));
      end
      if (m_phase == 2) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_result", 64'(rsp_result), 64'(m_r));
        chk("rsp_flags", 64'(rsp_flags), 64'(m_f));
      end
      if (rst_n) begin
        case (m_phase)
          0: if (g >= 0) begin
               m_id = g;
               m_a = ra[g[IDW-1:0]]; m_b = rb[g[IDW-1:0]]; m_c = rc[g[IDW-1:0]];
               {m_f, m_r} = alu_fn(m_a, m_b, m_c);
               m_ptr = (g + 1) % NREQ;
               m_rem = 1 + ((m_c == 3'b100) ? MW : 0);
               m_phase = 1;
             end
          1: begin m_rem--; if (m_rem == 0) m_phase = 2; end
          default: if (rsp_ready) m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        break;
      end
      @(posedge clk); #1;
    end
    if (g < 0) begin
      checks++; failures++;
      $display("FAIL grant_timeout actual=none required=grant");
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  // Issue one op on lane i, check latency and the literal result, optionally stall the response.
  task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic [31:0] er, input logic [3:0] ef,
                         input int lat_exp, input int hold);
    int g, lat;
    ra[i] = a; rb[i] = b; rc[i] = c;
    rsp_ready = (hold == 0);
    req_valid = '0; req_valid[i] = 1'b1;
    wait_grant(g);
    chk("grant_lane", 64'(g), 64'(i));
    lat = 0;
    step(); req_valid = '0;
    @(negedge clk); lat++;
    while (!rsp_valid && lat < 10) begin step(); @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'(lat_exp));
    chk("lit_result", 64'(rsp_result), 64'(er));
    chk("lit_flags", 64'(rsp_flags), 64'(ef));
    chk("lit_id", 64'(rsp_id), 64'(i));
    for (int h = 0; h < hold; h++) begin
      step(); req_valid = '1;
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'(1));
      chk("hold_busy", 64'(busy), 64'(1));
      chk("hold_no_grant", 64'(req_ready), 64'(0));
      chk("hold_result", 64'(rsp_result), 64'(er));
    end
    if (hold > 0) begin step(); rsp_ready = 1'b1; req_valid = '0; end
    step(); req_valid = '0;
    step();
  endtask

  initial begin
    int g;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; rc[i] = '0; end
    step(); step();
    rst_n = 1'b1;
    step();

    run_one(0, 32'd5, 32'd3, 3'b000, 32'd8, 4'b0000, 2, 0);
    run_one(2, 32'd7, 32'd6, 3'b100, 32'd42, 4'b0000, 3, 0);
    run_one(1, 32'd9, 32'd9, 3'b000, 32'd18, 4'b0000, 2, 5);

    // Pointer now at 2: a multiply on lane 2 moves it to 3, then reset mid-WAIT.
    ra[2] = 32'd3; rb[2] = 32'd4; rc[2] = 3'b100; rsp_ready = 1'b1;
    req_valid = 4'b0100;
    wait_grant(g);
    chk("pre_reset_grant", 64'(g), 64'(2));
    step(); req_valid = '0;
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    step(); rst_n = 1'b1;
    ra[1] = 32'd1; rb[1] = 32'd2; rc[1] = 3'b000; ra[3] = 32'd4; rb[3] = 32'd4; rc[3] = 3'b010;
    req_valid = 4'b1010;
    wait_grant(g);
    chk("post_reset_grant", 64'(g), 64'(1));
    step(); req_valid = '0;
    repeat (4) step();

    do_reset();
    for (int i = 0; i < NREQ; i++) begin ra[i] = 32'(i + 10); rb[i] = 32'(i); rc[i] = 3'(i); end
    req_valid = '1; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'(k % NREQ));
      step();
    end
    req_valid = '0;
    repeat (4) step();

    run_one(0, 32'd1, 32'd31, 3'b111, 32'h8000_0000, 4'b0000, 2, 0);
    run_one(1, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 4'b1010, 2, 0);

    for (int n = 0; n < 1500; n++) begin
      step();
      rst_n = ($urandom_range(0, 199) != 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        ra[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
        rb[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
        rc[i] = 3'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    step(); rst_n = 1'b1; req_valid = '0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
